// File: rtl/fp16_dot_feeder.sv
// Sequencer that streams buffered fp16 operand pairs into the dot-product MAC over start/done.
// Optional handshake watchdog: define FEEDER_TIMEOUT_EN.
module fp16_dot_feeder #(
  parameter int DEPTH   = 12,
  parameter int AW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk83,
  input  logic          reset83,
  input  logic          wr_en83,
  input  logic [AW-1:0] wr_addr83,
  input  logic [15:0]   wr_a83,
  input  logic [15:0]   wr_b83,
  input  logic [AW:0]   len83,
  input  logic          go83,
  output logic          busy83,
  output logic          start83,
  output logic [15:0]   a83,
  output logic [15:0]   b83,
  input  logic          done83,
  input  logic [15:0]   ans83,
  output logic [15:0]   result83,
  output logic          result_valid83,
  output logic          err83
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_DRIVE   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;
  localparam logic [AW:0] DEPTH_L  = (AW+1)'(DEPTH);

  logic [15:0] mem_a [0:DEPTH-1];
  logic [15:0] mem_b [0:DEPTH-1];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [AW:0]   len_q, len_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic [15:0]   a_q, a_d;
  logic [15:0]   b_q, b_d;
  logic [15:0]   result_q, result_d;
  logic          rv_q, rv_d;
  logic          err_q, err_d;
  logic [AW-1:0] idx_nxt;
  logic          last;

`ifdef FEEDER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  // Operand buffers are not reset and are frozen while a sequence runs.
  always_ff @(posedge clk83) begin
    if (wr_en83 && !busy_q && ({1'b0, wr_addr83} < DEPTH_L)) begin
      mem_a[wr_addr83] <= wr_a83;
      mem_b[wr_addr83] <= wr_b83;
    end
  end

  assign idx_nxt = idx_q + 1'b1;
  assign last    = ({1'b0, idx_q} == (len_q - 1'b1));

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    len_d    = len_q;
    start_d  = start_q;
    busy_d   = busy_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    rv_d     = 1'b0;
    err_d    = 1'b0;
`ifdef FEEDER_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (go83) begin
          if ((len83 != '0) && (len83 <= DEPTH_L)) begin
            len_d   = len83;
            idx_d   = '0;
            a_d     = mem_a[0];
            b_d     = mem_b[0];
            start_d = 1'b1;
            busy_d  = 1'b1;
            state_d = S_DRIVE;
`ifdef FEEDER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        if (done83) begin
          if (last) result_d = ans83;
          start_d = 1'b0;
          state_d = S_RELEASE;
`ifdef FEEDER_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      S_RELEASE: begin
        if (!done83) begin
          if (last) begin
            rv_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_nxt;
            a_d     = mem_a[idx_nxt];
            b_d     = mem_b[idx_nxt];
            start_d = 1'b1;
            state_d = S_DRIVE;
`ifdef FEEDER_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
`ifdef FEEDER_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: begin
        start_d = 1'b0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk83 or posedge reset83) begin
    if (reset83) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      start_q  <= 1'b0;
      busy_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      rv_q     <= 1'b0;
      err_q    <= 1'b0;
`ifdef FEEDER_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      start_q  <= start_d;
      busy_q   <= busy_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      rv_q     <= rv_d;
      err_q    <= err_d;
`ifdef FEEDER_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign busy83         = busy_q;
  assign start83        = start_q;
  assign a83            = a_q;
  assign b83            = b_q;
  assign result83       = result_q;
  assign result_valid83 = rv_q;
  assign err83          = err_q;

endmodule

// File: tb/tb_fp16_dot_feeder.sv
// Directed bench for fp16_dot_feeder with a behavioural MAC that answers from a table of hand-computed fp16 sums.
module tb_fp16_dot_feeder;
  localparam int AW = 4;

  logic        clk83 = 1'b0;
  logic        reset83 = 1'b1;
  logic        wr_en83 = 1'b0;
  logic [AW-1:0] wr_addr83 = '0;
  logic [15:0] wr_a83 = '0, wr_b83 = '0;
  logic [AW:0] len83 = '0;
  logic        go83 = 1'b0;
  logic        busy83, start83, result_valid83, err83;
  logic [15:0] a83, b83, result83;
  logic        done83 = 1'b0;
  logic [15:0] ans83 = '0;

  int checks = 0, failures = 0;

  // MAC model / monitor state
  logic        mac_en = 1'b0;
  int          wait_cnt = 0, pair_k = 0, starts = 0, rv_cnt = 0, rv_busy_bad = 0;
  int          stable_bad = 0, err_cnt = 0;
  logic [15:0] ans_tbl [0:3];
  logic [15:0] log_a [0:15];
  logic [15:0] log_b [0:15];
  logic [15:0] cur_a = '0, cur_b = '0;

  fp16_dot_feeder #(.DEPTH(12), .AW(AW), .TIMEOUT(64)) dut (
    .clk83(clk83), .reset83(reset83), .wr_en83(wr_en83), .wr_addr83(wr_addr83),
    .wr_a83(wr_a83), .wr_b83(wr_b83), .len83(len83), .go83(go83), .busy83(busy83),
    .start83(start83), .a83(a83), .b83(b83), .done83(done83), .ans83(ans83),
    .result83(result83), .result_valid83(result_valid83), .err83(err83)
  );

  always #5 clk83 = ~clk83;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural MAC: done two cycles after start, dropped after start falls.
  always begin
    @(posedge clk83);
    #1;
    if (result_valid83) begin
      rv_cnt++;
      if (busy83) rv_busy_bad++;
    end
    if (err83) err_cnt++;
    if (!mac_en) begin
      done83 = 1'b0;
    end else if (start83 && !done83) begin
      if (wait_cnt == 0) begin
        if (starts < 16) begin
          log_a[starts] = a83;
          log_b[starts] = b83;
        end
        starts++;
        cur_a = a83;
        cur_b = b83;
      end else if (a83 !== cur_a || b83 !== cur_b) begin
        stable_bad++;
      end
      wait_cnt++;
      if (wait_cnt == 2) begin
        done83 = 1'b1;
        ans83  = ans_tbl[pair_k];
      end
    end else if (!start83 && done83) begin
      done83   = 1'b0;
      wait_cnt = 0;
      pair_k++;
    end
  end

  task automatic mac_clear();
    done83 = 1'b0; wait_cnt = 0; pair_k = 0; starts = 0;
    rv_cnt = 0; rv_busy_bad = 0; stable_bad = 0; err_cnt = 0;
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk83);
    wr_en83 = 1'b1; wr_addr83 = addr; wr_a83 = a; wr_b83 = b;
    @(negedge clk83);
    wr_en83 = 1'b0;
  endtask

  task automatic go_pulse(input logic [AW:0] n);
    @(negedge clk83);
    go83 = 1'b1; len83 = n;
    @(posedge clk83);
    #1;
    go83 = 1'b0;
  endtask

  task automatic wait_rv(input int n, input int budget);
    for (int i = 0; i < budget && rv_cnt < n; i++) @(posedge clk83);
    #2;
    check("rv_arrived", rv_cnt, n);
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_start", start83, 0);
    check("rst_busy", busy83, 0);
    check("rst_ab", {a83, b83}, 0);
    check("rst_res", result83, 0);
    check("rst_pulses", {result_valid83, err83}, 0);
    @(negedge clk83);
    reset83 = 1'b0;

    // Three-pair dot product: 1*2 + 2*2 + 1*1 = 7
    wr(0, 16'h3C00, 16'h4000);
    wr(1, 16'h4000, 16'h4000);
    wr(2, 16'h3C00, 16'h3C00);
    ans_tbl[0] = 16'h4000; ans_tbl[1] = 16'h4600; ans_tbl[2] = 16'h4700;
    mac_clear();
    mac_en = 1'b1;
    go_pulse(3);
    check("go_start", start83, 1);
    check("go_busy", busy83, 1);
    check("go_slot0", {a83, b83}, {16'h3C00, 16'h4000});
    wait_rv(1, 200);
    check("dot3_starts", starts, 3);
    check("dot3_ops1", {log_a[1], log_b[1]}, {16'h4000, 16'h4000});
    check("dot3_ops2", {log_a[2], log_b[2]}, {16'h3C00, 16'h3C00});
    check("dot3_result", result83, 16'h4700);
    check("dot3_busy_at_rv", rv_busy_bad, 0);
    check("dot3_stable", stable_bad, 0);
    repeat (5) @(posedge clk83);
    #2;
    check("dot3_one_rv", rv_cnt, 1);
    check("dot3_idle", {busy83, start83}, 0);

    // Bad lengths
    go_pulse(0);
    check("len0_err", err83, 1);
    check("len0_idle", {start83, busy83}, 0);
    @(posedge clk83); #1;
    check("len0_pulse", err83, 0);
    go_pulse(13);
    check("len13_err", err83, 1);
    check("len13_idle", {start83, busy83}, 0);
    @(posedge clk83); #1;
    check("len13_pulse", err83, 0);

    // Busy protection: 2*2 + 1*3 = 7
    wr(0, 16'h4000, 16'h4000);
    wr(1, 16'h3C00, 16'h4200);
    ans_tbl[0] = 16'h4400; ans_tbl[1] = 16'h4700;
    mac_clear();
    go_pulse(2);
    @(negedge clk83);
    wr_en83 = 1'b1; wr_addr83 = 1; wr_a83 = 16'hFFFF; wr_b83 = 16'hFFFF;
    go83 = 1'b1; len83 = 2;
    @(negedge clk83);
    wr_en83 = 1'b0; go83 = 1'b0;
    wait_rv(1, 200);
    check("busy_slot1", {log_a[1], log_b[1]}, {16'h3C00, 16'h4200});
    check("busy_result", result83, 16'h4700);
    repeat (10) @(posedge clk83);
    #2;
    check("busy_no_rerun", starts, 2);
    check("busy_idle", busy83, 0);

    // Reset during DRIVE
    mac_en = 1'b0;
    mac_clear();
    go_pulse(1);
    repeat (3) @(posedge clk83);
    #1;
    check("hold_start", start83, 1);
    @(negedge clk83);
    #2;
    reset83 = 1'b1;
    #1;
    check("arst_start", start83, 0);
    check("arst_busy", busy83, 0);
    check("arst_data", {a83, b83, result83}, 0);
    @(negedge clk83);
    reset83 = 1'b0;
    mac_clear();
    mac_en = 1'b1;
    ans_tbl[0] = 16'h4400;
    go_pulse(1);
    check("rerun_slot0", {a83, b83}, {16'h4000, 16'h4000});
    wait_rv(1, 100);
    check("rerun_result", result83, 16'h4400);

    // Same-edge write to slot 0 with go: old slot 0 is issued
    mac_clear();
    @(negedge clk83);
    wr_en83 = 1'b1; wr_addr83 = 0; wr_a83 = 16'h3C00; wr_b83 = 16'h3C00;
    go83 = 1'b1; len83 = 1;
    @(posedge clk83); #1;
    wr_en83 = 1'b0; go83 = 1'b0;
    check("same_edge_old", {a83, b83}, {16'h4000, 16'h4000});
    wait_rv(1, 100);

    // Stalled MAC: done never rises
    mac_en = 1'b0;
    mac_clear();
    go_pulse(1);
    check("stall_new_slot0", {a83, b83}, {16'h3C00, 16'h3C00});
`ifdef FEEDER_TIMEOUT_EN
    repeat (63) @(posedge clk83);
    #1;
    check("to_early", err83, 0);
    @(posedge clk83); #1;
    check("to_err", err83, 1);
    check("to_idle", {start83, busy83}, 0);
    check("to_result", result83, 16'h4400);
    check("to_no_rv", rv_cnt, 0);
`else
    repeat (1100) @(posedge clk83);
    #2;
    check("stall_start", start83, 1);
    check("stall_busy", busy83, 1);
    check("stall_no_err", err_cnt, 0);
    @(negedge clk83);
    reset83 = 1'b1;
    @(negedge clk83);
    reset83 = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
